instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage feeding the core's instruction decode path. Owns the PC and issues one word
//   read at a time to an instruction memory with variable latency (valid/ready request,
//   valid response). It presents the fetched word and its PC to the core on a valid/ready
//   pair, and on a redirect (branch/jump) it discards any in-flight stale response.
// PARAMETERS
//   ADDR_WIDTH  16        PC / instruction-memory byte-address width
//   DATA_WIDTH  32        instruction word width
//   RESET_PC    'h0000    PC loaded on reset; bits [1:0] must be 0
// PORTS
//   clk              in   1           single clock, all state updates on rising edge
//   rst              in   1           synchronous, active-high reset
//   redirect_valid   in   1           core requests PC change this cycle
//   redirect_pc      in   ADDR_WIDTH  new PC; bits [1:0] are forced to 0 internally
//   instr_valid      out  1           instr/instr_pc hold a valid fetched word
//   instr_ready      in   1           core accepts instr this cycle
//   instr            out  DATA_WIDTH  fetched instruction
//   instr_pc         out  ADDR_WIDTH  byte address of instr
//   mem_req_valid    out  1           read request to instruction memory
//   mem_req_ready    in   1           memory accepts request
//   mem_addr         out  ADDR_WIDTH  request byte address (= current PC)
//   mem_resp_valid   in   1           read data returned (1-cycle pulse per accepted request)
//   mem_resp_data    in   DATA_WIDTH  read data
//   protocol_err     out  1           sticky: response arrived with no request outstanding
// BEHAVIOUR
//   - Reset: pc=RESET_PC, state=FETCH, instr_valid=0, instr=0, instr_pc=0, mem_req_valid=0,
//     protocol_err=0. mem_req_valid first asserts in the first cycle after rst deasserts.
//   - All outputs are registered or decoded from state; no combinational path from inputs.
//   - Maximum of one outstanding request. FSM states:
//     FETCH: mem_req_valid=1, mem_addr=pc. On mem_req_ready -> WAIT.
//     WAIT : await mem_resp_valid; on it, capture instr=data, instr_pc=pc -> HOLD.
//            instr_valid rises the cycle after mem_resp_valid (1-cycle latency).
//     HOLD : instr_valid=1, instr/instr_pc stable. On instr_ready: pc<=pc+4 -> FETCH.
//     DROP : stale request in flight; on mem_resp_valid discard data -> FETCH.
//   - Redirect (pc<=redirect_pc & ~3) takes priority over sequential increment in every state:
//     FETCH, request not accepted -> stay FETCH, next request uses new pc.
//     FETCH with mem_req_ready same cycle -> DROP (issued request is stale).
//     WAIT without resp -> DROP; WAIT with resp same cycle -> response discarded, -> FETCH.
//     HOLD -> FETCH, instr_valid drops next cycle; if instr_ready was also high, the
//       handshake counts as completed (core consumed it) but no +4 is applied.
//     DROP -> stay DROP (or FETCH if resp arrives same cycle); pc updated.
//   - PC arithmetic: pc+4 modulo 2^ADDR_WIDTH (wraps from max-3 to 0, no flag).
//   - mem_resp_valid in FETCH or HOLD: ignored, protocol_err<=1 (cleared only by rst).
//   - rst asserted mid-request: FSM returns to FETCH; any response arriving afterwards for the
//     pre-reset request is a memory-side violation and sets protocol_err.
//   - Throughput: minimum 3 cycles per instruction (FETCH, WAIT, HOLD) with zero-latency memory.
// STRUCTURE
//   - Shared package: state encoding localparams (S_FETCH, S_WAIT, S_HOLD, S_DROP), constant
//     PC_STEP=4, address-alignment mask.
//   - Sub-module: reuse existing adder (width ADDR_WIDTH) for pc+4; everything else in one
//     module (FSM, PC register, output holding register).
// TESTING
//   1. Reset, mem always ready, 1-cycle resp, instr_ready=1, RESET_PC=0 -> instr_pc sequence
//      0,4,8,C; instr matches memory words; instr_valid=0 during rst.
//   2. Resp delayed 5 cycles at pc=0x10 -> instr_valid stays 0, mem_req_valid=0 while waiting;
//      instr_valid=1 exactly one cycle after mem_resp_valid.
//   3. instr_ready=0 for 4 cycles in HOLD -> instr/instr_pc stable, no new mem request issued.
//   4. Redirect to 0x41 while in WAIT for pc=0x8 -> stale word discarded, next mem_addr=0x40,
//      next delivered instr_pc=0x40; word for 0x8 never presented.
//   5. pc=0xFFFC, ADDR_WIDTH=16, accept -> next mem_addr=0x0000.
//   6. mem_resp_valid pulsed while in HOLD -> protocol_err=1 and stays 1 until rst; held instr
//      unchanged.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and PC constants.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_e;

    localparam int unsigned PC_STEP    = 4;
    // Low PC bits that must be zero for word alignment.
    localparam int unsigned ALIGN_MASK = 3;

endpackage

// File: rtl/instr_fetch_unit_adder.sv
// Plain modular adder; used by the fetch unit for the sequential pc+4 step.
module instr_fetch_unit_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    // Carry out is discarded, so the result wraps modulo 2^WIDTH.
    assign sum = a + b;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps at most one read outstanding to instruction memory and
// hands each fetched word to the core on a valid/ready pair; redirects squash stale reads.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_FETCH | request for pc is being offered to memory
//   S_WAIT  | request accepted, waiting for its response
//   S_HOLD  | fetched word presented to the core until instr_ready
//   S_DROP  | redirected while a request was in flight; discard its response
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  protocol_err
);

    import instr_fetch_unit_pkg::*;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  protocol_err_q, protocol_err_d;
    logic                  req_en_q, req_en_d;

    logic [ADDR_WIDTH-1:0] pc_next_seq;
    logic [ADDR_WIDTH-1:0] redirect_pc_aligned;
    logic                  req_fire;

    instr_fetch_unit_adder #(
        .WIDTH (ADDR_WIDTH)
    ) u_pc_adder (
        .a   (pc_q),
        .b   (ADDR_WIDTH'(PC_STEP)),
        .sum (pc_next_seq)
    );

    assign redirect_pc_aligned = redirect_pc & ~ADDR_WIDTH'(ALIGN_MASK);

    // req_en_q keeps the request low while rst is held; it first rises on the edge
    // that samples rst low, so nothing in the output path depends on rst directly.
    assign mem_req_valid = req_en_q && (state_q == S_FETCH);
    assign mem_addr      = pc_q;
    assign instr_valid   = (state_q == S_HOLD);
    assign instr         = instr_q;
    assign instr_pc      = instr_pc_q;
    assign protocol_err  = protocol_err_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        instr_pc_d     = instr_pc_q;
        protocol_err_d = protocol_err_q;
        req_en_d       = 1'b1;

        unique case (state_q)
            S_FETCH: begin
                if (mem_resp_valid) begin
                    protocol_err_d = 1'b1;
                end
                if (redirect_valid) begin
                    pc_d    = redirect_pc_aligned;
                    state_d = req_fire ? S_DROP : S_FETCH;
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    if (redirect_valid) begin
                        pc_d    = redirect_pc_aligned;
                        state_d = S_FETCH;
                    end else begin
                        instr_d    = mem_resp_data;
                        instr_pc_d = pc_q;
                        state_d    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_d    = redirect_pc_aligned;
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (mem_resp_valid) begin
                    protocol_err_d = 1'b1;
                end
                // A redirect alongside instr_ready still completes the handshake, but the
                // redirect target replaces the sequential increment.
                if (redirect_valid) begin
                    pc_d    = redirect_pc_aligned;
                    state_d = S_FETCH;
                end else if (instr_ready) begin
                    pc_d    = pc_next_seq;
                    state_d = S_FETCH;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc_aligned;
                end
                if (mem_resp_valid) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_FETCH;
            pc_q           <= RESET_PC;
            instr_q        <= '0;
            instr_pc_q     <= '0;
            protocol_err_q <= 1'b0;
            req_en_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            instr_pc_q     <= instr_pc_d;
            protocol_err_q <= protocol_err_d;
            req_en_q       <= req_en_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit against a variable-latency instruction memory model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        protocol_err;

    int n_checks = 0;
    int n_fails  = 0;

    // memory model controls
    int          lat;
    logic        inject;
    logic        pend;
    int          cnt;
    logic [15:0] paddr;

    instr_fetch_unit #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .protocol_err   (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    // Response arrives lat cycles after the accepting edge; inject forces a spurious pulse.
    always @(posedge clk) begin
        if (rst) begin
            pend           <= 1'b0;
            cnt            <= 0;
            paddr          <= '0;
            mem_resp_valid <= 1'b0;
            mem_resp_data  <= '0;
        end else begin
            mem_resp_valid <= inject;
            if (pend) begin
                if (cnt == 1) begin
                    mem_resp_valid <= 1'b1;
                    mem_resp_data  <= mem_word(paddr);
                    pend           <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                pend  <= 1'b1;
                cnt   <= lat;
                paddr <= mem_addr;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!instr_valid && n < max) begin
            step();
            n++;
        end
        check("wait_instr_valid", 32'(instr_valid), 32'd1);
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        mem_req_ready  = 1'b1;
        lat            = 1;
        inject         = 1'b0;
        step();
        step();
        step();

        // reset state
        check("rst_instr_valid",   32'(instr_valid),   32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_protocol_err",  32'(protocol_err),  32'd0);
        check("rst_instr",         instr,              32'h0);
        check("rst_instr_pc",      32'(instr_pc),      32'h0);

        rst = 1'b0;
        check("pre_req_low", 32'(mem_req_valid), 32'd0);
        step();
        check("first_req_valid", 32'(mem_req_valid), 32'd1);
        check("first_req_addr",  32'(mem_addr),      32'h0);

        // sequential fetch 0,4,8,C
        for (int k = 0; k < 4; k++) begin
            wait_valid(20);
            check("seq_instr_pc", 32'(instr_pc), 32'(k * 4));
            check("seq_instr",    instr,         mem_word(16'(k * 4)));
            step();
        end

        // delayed response at pc=0x10
        lat = 5;
        check("pc10_addr", 32'(mem_addr), 32'h10);
        step();
        n = 0;
        while (!mem_resp_valid && n < 20) begin
            check("wait_instr_valid_low", 32'(instr_valid),   32'd0);
            check("wait_req_low",         32'(mem_req_valid), 32'd0);
            step();
            n++;
        end
        check("resp_seen",          32'(mem_resp_valid), 32'd1);
        check("resp_cycle_valid_0", 32'(instr_valid),    32'd0);
        instr_ready = 1'b0;
        step();
        check("resp_next_valid", 32'(instr_valid), 32'd1);
        check("resp_next_pc",    32'(instr_pc),    32'h10);

        // core stalls for 4 cycles in HOLD
        for (int k = 0; k < 4; k++) begin
            check("stall_valid",   32'(instr_valid),   32'd1);
            check("stall_pc",      32'(instr_pc),      32'h10);
            check("stall_instr",   instr,              mem_word(16'h10));
            check("stall_no_req",  32'(mem_req_valid), 32'd0);
            step();
        end
        instr_ready = 1'b1;
        lat         = 1;
        step();
        check("after_stall_req",  32'(mem_req_valid), 32'd1);
        check("after_stall_addr", 32'(mem_addr),      32'h14);

        // redirect to 0x8 while memory refuses, then redirect to 0x41 during WAIT
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0008;
        step();
        redirect_valid = 1'b0;
        check("redir8_addr", 32'(mem_addr),      32'h8);
        check("redir8_req",  32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        lat           = 4;
        step();
        check("wait8_req_low", 32'(mem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0041;
        step();
        redirect_valid = 1'b0;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            check("drop_no_instr", 32'(instr_valid), 32'd0);
            step();
            n++;
        end
        lat = 1;
        check("drop_req_resume", 32'(mem_req_valid), 32'd1);
        check("drop_addr_40",    32'(mem_addr),      32'h40);
        wait_valid(20);
        check("redir_instr_pc", 32'(instr_pc), 32'h40);
        check("redir_instr",    instr,         mem_word(16'h40));
        step();
        check("after_40_addr", 32'(mem_addr), 32'h44);

        // PC wrap from 0xFFFC to 0x0000
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFC;
        step();
        redirect_valid = 1'b0;
        mem_req_ready  = 1'b1;
        wait_valid(20);
        check("wrap_instr_pc", 32'(instr_pc), 32'hFFFC);
        check("wrap_instr",    instr,         mem_word(16'hFFFC));
        step();
        check("wrap_addr", 32'(mem_addr),      32'h0);
        check("wrap_req",  32'(mem_req_valid), 32'd1);

        // spurious response while holding an instruction
        check("perr_before", 32'(protocol_err), 32'd0);
        instr_ready = 1'b0;
        wait_valid(20);
        inject = 1'b1;
        step();
        inject = 1'b0;
        step();
        check("perr_set",        32'(protocol_err), 32'd1);
        check("perr_hold_valid", 32'(instr_valid),  32'd1);
        check("perr_hold_pc",    32'(instr_pc),     32'h0);
        check("perr_hold_instr", instr,             mem_word(16'h0));
        instr_ready = 1'b1;
        step();
        step();
        step();
        check("perr_sticky", 32'(protocol_err), 32'd1);
        rst = 1'b1;
        step();
        check("perr_cleared", 32'(protocol_err), 32'd0);
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
